// File: rtl/calc1_arbiter.sv
// calc1_arbiter: shares one calc1 ALU between four requesters.
// Each port captures a command plus op1 in one cycle and op2 in the next.
// Invalid commands are rejected locally. Valid commands wait in a
// one-per-port slot until the round-robin FSM forwards them to the ALU.
// Ports:
//   c_clk, reset                 clock and synchronous active-high reset
//   req_cmd_in1..4, req_data_in1..4   requester command / operand inputs
//   out_resp1..4, out_data1..4   one-cycle response and result per port
//   port_busy1..4                port holds a captured, pending or in-flight command
//   alu_cmd, alu_data            command/operand stream to the shared ALU
//   alu_resp, alu_out_data       ALU response and result
module calc1_arbiter #(
  parameter int TIMEOUT_CYCLES = 32,
  parameter int DATA_W         = 32
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic [3:0]        req_cmd_in1,
  input  logic [3:0]        req_cmd_in2,
  input  logic [3:0]        req_cmd_in3,
  input  logic [3:0]        req_cmd_in4,
  input  logic [DATA_W-1:0] req_data_in1,
  input  logic [DATA_W-1:0] req_data_in2,
  input  logic [DATA_W-1:0] req_data_in3,
  input  logic [DATA_W-1:0] req_data_in4,
  output logic [1:0]        out_resp1,
  output logic [1:0]        out_resp2,
  output logic [1:0]        out_resp3,
  output logic [1:0]        out_resp4,
  output logic [DATA_W-1:0] out_data1,
  output logic [DATA_W-1:0] out_data2,
  output logic [DATA_W-1:0] out_data3,
  output logic [DATA_W-1:0] out_data4,
  output logic              port_busy1,
  output logic              port_busy2,
  output logic              port_busy3,
  output logic              port_busy4,
  output logic [3:0]        alu_cmd,
  output logic [DATA_W-1:0] alu_data,
  input  logic [1:0]        alu_resp,
  input  logic [DATA_W-1:0] alu_out_data
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE_CMD = 3'd1,
    ISSUE_OP2 = 3'd2,
    WAIT      = 3'd3,
    RETURN    = 3'd4
  } state_t;

  // Commands the ALU understands: add, sub, shl, shr.
  function automatic logic valid_cmd(input logic [3:0] cmd);
    case (cmd)
      4'd1, 4'd2, 4'd5, 4'd6: valid_cmd = 1'b1;
      default:                valid_cmd = 1'b0;
    endcase
  endfunction

  logic [3:0]        req_cmd  [4];
  logic [DATA_W-1:0] req_data [4];

  logic [3:0]        busy;
  logic [3:0]        op2_phase;  // op2 is on the data input this cycle
  logic [3:0]        reject;     // rejection response is being shown
  logic [3:0]        pending;
  logic [3:0]        slot_cmd [4];
  logic [DATA_W-1:0] slot_op1 [4];
  logic [DATA_W-1:0] slot_op2 [4];
  logic [1:0]        resp_q   [4];
  logic [DATA_W-1:0] data_q   [4];

  state_t            state;
  logic [1:0]        grant;
  logic [1:0]        last;
  logic [CNT_W-1:0]  wait_cnt;

  logic [1:0]        win;
  logic [1:0]        cand;
  logic              fin_valid;
  logic [1:0]        fin_resp;
  logic [DATA_W-1:0] fin_data;

  assign req_cmd[0]  = req_cmd_in1;
  assign req_cmd[1]  = req_cmd_in2;
  assign req_cmd[2]  = req_cmd_in3;
  assign req_cmd[3]  = req_cmd_in4;
  assign req_data[0] = req_data_in1;
  assign req_data[1] = req_data_in2;
  assign req_data[2] = req_data_in3;
  assign req_data[3] = req_data_in4;

  assign out_resp1  = resp_q[0];
  assign out_resp2  = resp_q[1];
  assign out_resp3  = resp_q[2];
  assign out_resp4  = resp_q[3];
  assign out_data1  = data_q[0];
  assign out_data2  = data_q[1];
  assign out_data3  = data_q[2];
  assign out_data4  = data_q[3];
  assign port_busy1 = busy[0];
  assign port_busy2 = busy[1];
  assign port_busy3 = busy[2];
  assign port_busy4 = busy[3];

  // Round-robin winner: scan from farthest to nearest so the nearest
  // pending port after the last grant ends up selected.
  always_comb begin
    win  = last;
    cand = last;
    for (int k = 4; k >= 1; k--) begin
      cand = last + 2'(k);
      if (pending[cand]) begin
        win = cand;
      end else begin
        win = win;
      end
    end
  end

  // End of WAIT: an ALU response wins over a timeout in the same cycle.
  always_comb begin
    fin_valid = 1'b0;
    fin_resp  = 2'd0;
    fin_data  = '0;
    if (state == WAIT) begin
      if (alu_resp != 2'd0) begin
        fin_valid = 1'b1;
        fin_resp  = alu_resp;
        fin_data  = alu_out_data;
      end else if (wait_cnt == CNT_LAST) begin
        fin_valid = 1'b1;
        fin_resp  = 2'd3;
        fin_data  = '0;
      end else begin
        fin_valid = 1'b0;
      end
    end else begin
      fin_valid = 1'b0;
    end
  end

  // Per-port capture, rejection, slot bookkeeping and response registers.
  always_ff @(posedge c_clk) begin
    if (reset) begin
      busy      <= 4'd0;
      op2_phase <= 4'd0;
      reject    <= 4'd0;
      pending   <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        slot_cmd[i] <= 4'd0;
        slot_op1[i] <= '0;
        slot_op2[i] <= '0;
        resp_q[i]   <= 2'd0;
        data_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        resp_q[i] <= 2'd0;
        data_q[i] <= '0;
        if ((state == RETURN) && (grant == 2'(i))) begin
          busy[i]    <= 1'b0;
          pending[i] <= 1'b0;
        end else if (reject[i]) begin
          busy[i]   <= 1'b0;
          reject[i] <= 1'b0;
        end else if (op2_phase[i]) begin
          slot_op2[i]  <= req_data[i];
          op2_phase[i] <= 1'b0;
          if (valid_cmd(slot_cmd[i])) begin
            pending[i] <= 1'b1;
          end else begin
            reject[i] <= 1'b1;
            resp_q[i] <= 2'd2;
          end
        end else if (!busy[i] && (req_cmd[i] != 4'd0)) begin
          slot_cmd[i]  <= req_cmd[i];
          slot_op1[i]  <= req_data[i];
          busy[i]      <= 1'b1;
          op2_phase[i] <= 1'b1;
        end
        // The FSM result lands in the cycle the FSM sits in RETURN.
        if (fin_valid && (grant == 2'(i))) begin
          resp_q[i] <= fin_resp;
          data_q[i] <= fin_data;
        end
      end
    end
  end

  // Arbitration FSM driving the shared ALU; alu outputs default to 0.
  always_ff @(posedge c_clk) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= 2'd0;
      last     <= 2'd3;  // so the first search starts at port 1
      wait_cnt <= '0;
      alu_cmd  <= 4'd0;
      alu_data <= '0;
    end else begin
      alu_cmd  <= 4'd0;
      alu_data <= '0;
      case (state)
        IDLE: begin
          if (|pending) begin
            grant    <= win;
            last     <= win;
            alu_cmd  <= slot_cmd[win];
            alu_data <= slot_op1[win];
            state    <= ISSUE_CMD;
          end
        end
        ISSUE_CMD: begin
          alu_data <= slot_op2[grant];
          state    <= ISSUE_OP2;
        end
        ISSUE_OP2: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (fin_valid) begin
            state <= RETURN;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        RETURN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc1_arbiter.sv
// Randomized bench for calc1_arbiter. The bench plays all four requesters
// and the ALU, and predicts every output from a timestamp model. The model
// records when each port captures, when each command becomes pending, when
// the arbiter is free, and at which cycle each response is due.
module tb_calc1_arbiter;
  localparam int DW   = 32;
  localparam int TMO  = 8;
  localparam int NCYC = 5000;
  localparam int INF  = 32'h3fff_ffff;

  logic          c_clk;
  logic          reset;
  logic [3:0]    cmd_d  [4];
  logic [DW-1:0] data_d [4];
  logic [1:0]    alu_resp;
  logic [DW-1:0] alu_out_data;
  logic [3:0]    alu_cmd;
  logic [DW-1:0] alu_data;
  logic [1:0]    obs_resp [4];
  logic [DW-1:0] obs_data [4];
  logic          obs_busy [4];

  calc1_arbiter #(.TIMEOUT_CYCLES(TMO), .DATA_W(DW)) dut (
    .c_clk(c_clk), .reset(reset),
    .req_cmd_in1(cmd_d[0]), .req_cmd_in2(cmd_d[1]),
    .req_cmd_in3(cmd_d[2]), .req_cmd_in4(cmd_d[3]),
    .req_data_in1(data_d[0]), .req_data_in2(data_d[1]),
    .req_data_in3(data_d[2]), .req_data_in4(data_d[3]),
    .out_resp1(obs_resp[0]), .out_resp2(obs_resp[1]),
    .out_resp3(obs_resp[2]), .out_resp4(obs_resp[3]),
    .out_data1(obs_data[0]), .out_data2(obs_data[1]),
    .out_data3(obs_data[2]), .out_data4(obs_data[3]),
    .port_busy1(obs_busy[0]), .port_busy2(obs_busy[1]),
    .port_busy3(obs_busy[2]), .port_busy4(obs_busy[3]),
    .alu_cmd(alu_cmd), .alu_data(alu_data),
    .alu_resp(alu_resp), .alu_out_data(alu_out_data)
  );

  always #5 c_clk = ~c_clk;

  int n_vec;
  int n_err;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_valid(input logic [3:0] c);
    return (c == 4'd1) || (c == 4'd2) || (c == 4'd5) || (c == 4'd6);
  endfunction

  // The bench's own ALU behaviour.
  function automatic logic [DW-1:0] alu_calc(input logic [3:0] c, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
    case (c)
      4'd1:    return a + b;
      4'd2:    return a - b;
      4'd5:    return a << b[4:0];
      4'd6:    return a >> b[4:0];
      default: return '0;
    endcase
  endfunction

  // Model state (cycle numbers)
  int            busy_from [4];
  int            free_at   [4];
  int            cap_t     [4];
  int            pend_from [4];
  bit            pend      [4];
  logic [3:0]    m_cmd     [4];
  logic [DW-1:0] m_op1     [4];
  logic [DW-1:0] m_op2     [4];
  int            ev_cyc    [4];
  logic [1:0]    ev_resp   [4];
  logic [DW-1:0] ev_data   [4];
  int            arb_free;
  int            last;
  int            g_port, g_cyc, w_cyc, wait_end;
  logic [3:0]    g_cmd;
  logic [DW-1:0] g_op1, g_op2;
  logic [1:0]    w_resp;
  logic [DW-1:0] w_data;

  task automatic model_reset(input int k);
    for (int i = 0; i < 4; i++) begin
      busy_from[i] = INF; free_at[i] = 0; cap_t[i] = -10;
      pend[i] = 1'b0; pend_from[i] = INF; ev_cyc[i] = -1;
    end
    arb_free = k + 1;
    last     = 3;
    g_port   = -1; g_cyc = -10; w_cyc = -1; wait_end = -1;
  endtask

  initial begin
    logic [3:0] vlist [4];
    logic [3:0] c;
    logic [DW-1:0] d;
    bit rst_now;
    bit burst;
    int dly;
    int p;
    vlist[0] = 4'd1; vlist[1] = 4'd2; vlist[2] = 4'd5; vlist[3] = 4'd6;
    c_clk = 1'b0;
    reset = 1'b1;
    alu_resp = 2'd0;
    alu_out_data = '0;
    for (int i = 0; i < 4; i++) begin
      cmd_d[i] = 4'd0;
      data_d[i] = '0;
    end
    n_vec = 0;
    n_err = 0;
    model_reset(-1);
    repeat (2) @(posedge c_clk);

    for (int k = 0; k < NCYC; k++) begin
      @(negedge c_clk);
      // ---- compare outputs of cycle k ----
      for (int i = 0; i < 4; i++) begin
        check_val($sformatf("resp%0d@%0d", i + 1, k), 32'(obs_resp[i]),
                  (ev_cyc[i] == k) ? 32'(ev_resp[i]) : 32'd0);
        check_val($sformatf("data%0d@%0d", i + 1, k), obs_data[i],
                  (ev_cyc[i] == k) ? ev_data[i] : 32'd0);
        check_val($sformatf("busy%0d@%0d", i + 1, k), 32'(obs_busy[i]),
                  ((k >= busy_from[i]) && (k < free_at[i])) ? 32'd1 : 32'd0);
      end
      check_val($sformatf("alu_cmd@%0d", k), 32'(alu_cmd),
                ((g_port >= 0) && (k == g_cyc + 1)) ? 32'(g_cmd) : 32'd0);
      check_val($sformatf("alu_data@%0d", k), alu_data,
                ((g_port >= 0) && (k == g_cyc + 1)) ? g_op1 :
                ((g_port >= 0) && (k == g_cyc + 2)) ? g_op2 : 32'd0);

      // ---- decide reset for this cycle ----
      rst_now = (k > 40) && ($urandom_range(0, 249) == 0);

      // ---- arbiter: grant at an idle cycle with something pending ----
      if (!rst_now && (k >= arb_free)) begin
        p = -1;
        for (int j = 1; j <= 4; j++) begin
          if ((p < 0) && pend[(last + j) % 4] && (pend_from[(last + j) % 4] <= k))
            p = (last + j) % 4;
        end
        if (p >= 0) begin
          g_port = p; g_cyc = k; last = p; pend[p] = 1'b0;
          g_cmd = m_cmd[p]; g_op1 = m_op1[p]; g_op2 = m_op2[p];
          dly = ($urandom_range(0, 3) == 0) ? TMO : $urandom_range(0, TMO - 1);
          if (dly < TMO) begin
            w_cyc = k + 3 + dly;
            if ($urandom_range(0, 4) == 0) begin
              w_resp = 2'($urandom_range(2, 3));
              w_data = $urandom;
            end else begin
              w_resp = 2'd1;
              w_data = alu_calc(g_cmd, g_op1, g_op2);
            end
            ev_cyc[p] = w_cyc + 1; ev_resp[p] = w_resp; ev_data[p] = w_data;
          end else begin
            w_cyc = -1;
            ev_cyc[p] = k + 3 + TMO; ev_resp[p] = 2'd3; ev_data[p] = '0;
          end
          wait_end   = ev_cyc[p] - 1;
          free_at[p] = ev_cyc[p] + 1;
          arb_free   = ev_cyc[p] + 1;
        end
      end

      // ---- ALU side: quiet during WAIT except the chosen cycle, noise elsewhere ----
      if ((g_port >= 0) && (k >= g_cyc + 3) && (k <= wait_end)) begin
        if (k == w_cyc) begin
          alu_resp = w_resp; alu_out_data = w_data;
        end else begin
          alu_resp = 2'd0; alu_out_data = $urandom;
        end
      end else begin
        alu_resp = 2'($urandom_range(0, 3)); alu_out_data = $urandom;
      end

      // ---- requesters ----
      burst = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < 4; i++) begin
        d = $urandom;
        if (burst) c = vlist[i];
        else if ($urandom_range(0, 2) != 0) c = 4'd0;
        else if ($urandom_range(0, 7) < 6) c = vlist[$urandom_range(0, 3)];
        else c = 4'($urandom_range(1, 15));
        cmd_d[i] = c; data_d[i] = d;
        if (k == cap_t[i] + 1) m_op2[i] = d;
        if (!rst_now && (c != 4'd0) && !((k >= busy_from[i]) && (k < free_at[i]))) begin
          cap_t[i] = k; m_cmd[i] = c; m_op1[i] = d; busy_from[i] = k + 1;
          if (is_valid(c)) begin
            pend[i] = 1'b1; pend_from[i] = k + 2; free_at[i] = INF;
          end else begin
            ev_cyc[i] = k + 2; ev_resp[i] = 2'd2; ev_data[i] = '0; free_at[i] = k + 3;
          end
        end
      end

      reset = rst_now;
      if (rst_now) model_reset(k);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
